add_sub_n_parts: RTL

ADD_SUB_N_PARTS -- requirements
Module: add_sub_n_parts

---
 rtl/add_sub_n_parts_pkg.sv | 17 +
 rtl/add_sub_n_parts_limb_add.sv | 28 ++
 rtl/add_sub_n_parts.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/add_sub_n_parts_pkg.sv
// Shared arithmetic package: FSM state encoding and the limb counter width.
package add_sub_n_parts_pkg;

    // Sequencer states of the multi-cycle adder/subtractor.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width of a counter that indexes PARTS limbs (never below one bit).
    function automatic int unsigned cnt_width(input int unsigned parts);
        int unsigned w;
        w = (parts < 2) ? 1 : int'($clog2(parts));
        return w;
    endfunction

endpackage

// File: rtl/add_sub_n_parts_limb_add.sv
// Combinational limb adder: s/cout = x + (invert_y ? ~y : y) + cin.
// Ports:
//   x, y      W-bit limb operands
//   cin       carry-in
//   invert_y  invert y (subtraction by two's complement)
//   s         W-bit limb sum
//   cout      carry-out of the limb
module limb_add #(
    parameter int unsigned W = 112
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    input  logic         invert_y,
    output logic [W-1:0] s,
    output logic         cout
);

    localparam int unsigned WE = W + 1;

    logic [W-1:0]  y_eff;
    logic [WE-1:0] total;

    assign y_eff       = invert_y ? ~y : y;
    assign total       = {1'b0, x} + {1'b0, y_eff} + WE'(cin);
    assign {cout, s}   = total;

endmodule

// File: rtl/add_sub_n_parts.sv
// Multi-cycle add/subtract: SIZE-bit operands processed one LIMB per clock.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request an operation (accepted only in IDLE)
//   sub     0 = a + b, 1 = a - b (sampled with start)
//   a, b    SIZE-bit operands (sampled with start)
//   result  {carry / borrow, SIZE-bit sum/difference}, updated on completion
//   done    high when idle with a valid result
module add_sub_n_parts
    import add_sub_n_parts_pkg::*;
#(
    parameter int unsigned SIZE  = 448,
    parameter int unsigned PARTS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            sub,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE:0]   result,
    output logic            done
);

    localparam int unsigned LIMB = SIZE / PARTS;
    localparam int unsigned CW   = cnt_width(PARTS);
    localparam int unsigned IW   = $clog2(SIZE);
    localparam int unsigned SW   = SIZE - LIMB;
    localparam logic [CW-1:0] LAST = CW'(PARTS - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            done_d;
    logic            holdoff_q, holdoff_d;
    logic            sub_q;
    logic [SIZE-1:0] a_q, b_q;
    logic [SW-1:0]   shadow_q;

    logic            load_c;
    logic            shadow_we_c;
    logic            result_we_c;
    logic            idle_c;
    logic [IW-1:0]   base_c;
    logic [SIZE-1:0] op_a_c, op_b_c;
    logic [LIMB-1:0] x_c, y_c, sum_c;
    logic            cin_c, inv_c, cout_c;

    // Limb 0 is computed straight from the ports on the accepting edge;
    // later limbs come from the latched operands at the counter's offset.
    assign idle_c = (state_q == IDLE);
    assign op_a_c = idle_c ? a : a_q;
    assign op_b_c = idle_c ? b : b_q;
    assign base_c = idle_c ? '0 : IW'(cnt_q) * IW'(LIMB);
    assign x_c    = op_a_c[base_c +: LIMB];
    assign y_c    = op_b_c[base_c +: LIMB];
    assign cin_c  = idle_c ? sub : carry_q;
    assign inv_c  = idle_c ? sub : sub_q;

    limb_add #(
        .W(LIMB)
    ) u_limb_add (
        .x        (x_c),
        .y        (y_c),
        .cin      (cin_c),
        .invert_y (inv_c),
        .s        (sum_c),
        .cout     (cout_c)
    );

    // Next-state and control decode.
    // holdoff keeps done visible for one full cycle after completion, so a
    // continuously held start yields one operation every PARTS+1 edges.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        done_d      = done;
        holdoff_d   = 1'b0;
        load_c      = 1'b0;
        shadow_we_c = 1'b0;
        result_we_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !holdoff_q) begin
                    load_c      = 1'b1;
                    shadow_we_c = 1'b1;
                    carry_d     = cout_c;
                    cnt_d       = CW'(1);
                    done_d      = 1'b0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                carry_d = cout_c;
                if (cnt_q == LAST) begin
                    result_we_c = 1'b1;
                    done_d      = 1'b1;
                    holdoff_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    shadow_we_c = 1'b1;
                    cnt_d       = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // FSM and sequencing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            done      <= 1'b1;
            holdoff_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            done      <= done_d;
            holdoff_q <= holdoff_d;
        end
    end

    // Operand latch, partial-limb shadow and final result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            shadow_q <= '0;
            result   <= '0;
        end else begin
            if (load_c) begin
                a_q   <= a;
                b_q   <= b;
                sub_q <= sub;
            end
            if (shadow_we_c) begin
                shadow_q[base_c +: LIMB] <= sum_c;
            end
            if (result_we_c) begin
                // For subtraction the top bit is a borrow, i.e. inverted carry.
                result <= {sub_q ? ~cout_c : cout_c, sum_c, shadow_q};
            end
        end
    end

endmodule
